// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM type and width helpers for the matmul tile sequencer
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int DEFAULT_NUM_CORES       = 2;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    // Width of a counter that must hold 0..max_outstanding inclusive.
    function automatic int osd_cnt_w(input int max_outstanding);
        return (max_outstanding < 1) ? 1 : $clog2(max_outstanding + 1);
    endfunction

    // One lane-mask bit per core in a column group.
    function automatic int lane_mask_w(input int num_cores);
        return num_cores;
    endfunction

endpackage

// File: rtl/tile_index_counter.sv
// rtl/tile_index_counter.sv - nested row/group/inner counter with running address bases
module tile_index_counter
    import matmul_pkg::*;
#(
    parameter int DIM_W     = 8,
    parameter int ADDR_W    = 14,
    parameter int NUM_CORES = DEFAULT_NUM_CORES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic [DIM_W-1:0]    k_tiles_i,
    input  logic [DIM_W-1:0]    row_tiles_i,
    input  logic [DIM_W-1:0]    col_tiles_i,
    output logic [DIM_W-1:0]    k_nxt_o,
    output logic [DIM_W+5:0]    c0_nxt_o,
    output logic [ADDR_W-1:0]   row_base_nxt_o,
    output logic [ADDR_W-1:0]   grp_base_nxt_o,
    output logic                last_k_o,
    output logic                last_beat_o
);

    // c0 needs headroom above col_tiles for the NUM_CORES step (up to 32).
    localparam int CW = DIM_W + 6;

    logic [DIM_W-1:0]  k_q, k_d, r_q, r_d;
    logic [CW-1:0]     c0_q, c0_d;
    logic [ADDR_W-1:0] rb_q, rb_d, gb_q, gb_d;
    logic              last_group, last_row;

    // rb tracks r*K and gb tracks g*K so no multiplier is needed.
    assign last_k_o    = (k_q == k_tiles_i - DIM_W'(1));
    assign last_group  = ((c0_q + CW'(NUM_CORES)) >= CW'(col_tiles_i));
    assign last_row    = (r_q == row_tiles_i - DIM_W'(1));
    assign last_beat_o = last_k_o && last_group && last_row;

    // Next counter values: k innermost, then column group, then row.
    always_comb begin
        k_d  = k_q;
        r_d  = r_q;
        c0_d = c0_q;
        rb_d = rb_q;
        gb_d = gb_q;
        if (clear_i) begin
            k_d  = '0;
            r_d  = '0;
            c0_d = '0;
            rb_d = '0;
            gb_d = '0;
        end else if (advance_i) begin
            if (last_k_o) begin
                k_d = '0;
                if (last_group) begin
                    c0_d = '0;
                    gb_d = '0;
                    r_d  = r_q + DIM_W'(1);
                    rb_d = rb_q + ADDR_W'(k_tiles_i);
                end else begin
                    c0_d = c0_q + CW'(NUM_CORES);
                    gb_d = gb_q + ADDR_W'(k_tiles_i);
                end
            end else begin
                k_d = k_q + DIM_W'(1);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q  <= '0;
            r_q  <= '0;
            c0_q <= '0;
            rb_q <= '0;
            gb_q <= '0;
        end else begin
            k_q  <= k_d;
            r_q  <= r_d;
            c0_q <= c0_d;
            rb_q <= rb_d;
            gb_q <= gb_d;
        end
    end

    assign k_nxt_o        = k_d;
    assign c0_nxt_o       = c0_d;
    assign row_base_nxt_o = rb_d;
    assign grp_base_nxt_o = gb_d;

endmodule

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - tile walk, BRAM addressing and retire tracking for the matmul cores
module matmul_tile_sequencer
    import matmul_pkg::*;
#(
    parameter int NUM_CORES       = DEFAULT_NUM_CORES,
    parameter int DIM_W           = 8,
    parameter int ADDR_W          = 14,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     cfg_k_tiles,
    input  logic [DIM_W-1:0]     cfg_row_tiles,
    input  logic [DIM_W-1:0]     cfg_col_tiles,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [ADDR_W-1:0]    in_addr,
    output logic [ADDR_W-1:0]    wb_addr,
    output logic                 first_k,
    output logic                 last_k,
    output logic [NUM_CORES-1:0] lane_mask,
    input  logic                 res_valid,
    output logic                 out_we,
    output logic [ADDR_W-1:0]    out_addr
);

    localparam int OW = osd_cnt_w(MAX_OUTSTANDING);
    localparam int LW = lane_mask_w(NUM_CORES);
    localparam int CW = DIM_W + 6;

    seq_state_e        state_q, state_d;
    logic [DIM_W-1:0]  cfg_k_q, cfg_k_d, cfg_r_q, cfg_r_d, cfg_c_q, cfg_c_d;
    logic [DIM_W-1:0]  k_eff, r_eff, c_eff;
    logic              err_q, err_d;
    logic [OW-1:0]     osd_q, osd_d;
    logic [ADDR_W-1:0] retire_q, retire_d;
    logic              ready_q, done_q, iv_q, iv_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d, wb_addr_q, wb_addr_d;
    logic              first_q, first_d, last_q, last_d;
    logic [LW-1:0]     lane_q, lane_d;

    logic              start_acc, cfg_zero, beat, retire_ok, grp_done;
    logic              cnt_last_k, cnt_last_beat;
    logic [DIM_W-1:0]  k_nxt;
    logic [CW-1:0]     c0_nxt;
    logic [ADDR_W-1:0] row_base_nxt, grp_base_nxt;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign cfg_zero  = (cfg_k_tiles == '0) || (cfg_row_tiles == '0) || (cfg_col_tiles == '0);
    assign beat      = iv_q && issue_ready;
    assign retire_ok = res_valid && (osd_q != '0);
    assign grp_done  = beat && cnt_last_k;

    // The counter is cleared in the same cycle cfg is latched, so it sees the live inputs then.
    assign k_eff = (state_q == ST_IDLE) ? cfg_k_tiles   : cfg_k_q;
    assign r_eff = (state_q == ST_IDLE) ? cfg_row_tiles : cfg_r_q;
    assign c_eff = (state_q == ST_IDLE) ? cfg_col_tiles : cfg_c_q;

    tile_index_counter #(
        .DIM_W     (DIM_W),
        .ADDR_W    (ADDR_W),
        .NUM_CORES (NUM_CORES)
    ) u_cnt (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (start_acc),
        .advance_i      (beat),
        .k_tiles_i      (k_eff),
        .row_tiles_i    (r_eff),
        .col_tiles_i    (c_eff),
        .k_nxt_o        (k_nxt),
        .c0_nxt_o       (c0_nxt),
        .row_base_nxt_o (row_base_nxt),
        .grp_base_nxt_o (grp_base_nxt),
        .last_k_o       (cnt_last_k),
        .last_beat_o    (cnt_last_beat)
    );

    // FSM, config latch, outstanding/retire bookkeeping and next beat outputs.
    always_comb begin
        state_d  = state_q;
        cfg_k_d  = cfg_k_q;
        cfg_r_d  = cfg_r_q;
        cfg_c_d  = cfg_c_q;
        err_d    = err_q;
        osd_d    = osd_q;
        retire_d = retire_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_k_d  = cfg_k_tiles;
                    cfg_r_d  = cfg_row_tiles;
                    cfg_c_d  = cfg_col_tiles;
                    err_d    = cfg_zero;
                    retire_d = '0;
                    state_d  = cfg_zero ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: if (beat && cnt_last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (osd_q == '0) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        // Simultaneous group issue and retire cancel out.
        if (grp_done && !retire_ok) begin
            osd_d = osd_q + OW'(1);
        end else if (!grp_done && retire_ok) begin
            osd_d = osd_q - OW'(1);
        end
        if (retire_ok) retire_d = retire_q + ADDR_W'(1);
        if (res_valid && (osd_q == '0)) err_d = 1'b1;

        // Hold off a new group until a slot is free; mid-group beats never stall on it.
        iv_d = (state_d == ST_ISSUE) && !((k_nxt == '0) && (osd_d == OW'(MAX_OUTSTANDING)));
        in_addr_d = row_base_nxt + ADDR_W'(k_nxt);
        wb_addr_d = grp_base_nxt + ADDR_W'(k_nxt);
        first_d   = (k_nxt == '0);
        last_d    = (k_nxt == k_eff - DIM_W'(1));
        lane_d    = '0;
        for (int i = 0; i < LW; i++) begin
            lane_d[i] = ((c0_nxt + CW'(i)) < CW'(c_eff));
        end
    end

    // State and registered outputs; beat outputs only move on start or an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cfg_k_q   <= '0;
            cfg_r_q   <= '0;
            cfg_c_q   <= '0;
            err_q     <= 1'b0;
            osd_q     <= '0;
            retire_q  <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            iv_q      <= 1'b0;
            in_addr_q <= '0;
            wb_addr_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            lane_q    <= '0;
        end else begin
            state_q  <= state_d;
            cfg_k_q  <= cfg_k_d;
            cfg_r_q  <= cfg_r_d;
            cfg_c_q  <= cfg_c_d;
            err_q    <= err_d;
            osd_q    <= osd_d;
            retire_q <= retire_d;
            ready_q  <= (state_d == ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            iv_q     <= iv_d;
            if (start_acc || beat) begin
                in_addr_q <= in_addr_d;
                wb_addr_q <= wb_addr_d;
                first_q   <= first_d;
                last_q    <= last_d;
                lane_q    <= lane_d;
            end
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign issue_valid = iv_q;
    assign in_addr     = in_addr_q;
    assign wb_addr     = wb_addr_q;
    assign first_k     = first_q;
    assign last_k      = last_q;
    assign lane_mask   = lane_q;
    assign out_we      = retire_ok;
    assign out_addr    = retire_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - directed self-checking bench for matmul_tile_sequencer
module tb_matmul_tile_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, issue_ready, res_valid;
    logic [7:0]  cfg_k_tiles, cfg_row_tiles, cfg_col_tiles;
    logic        ready, done, err, issue_valid, first_k, last_k, out_we;
    logic [13:0] in_addr, wb_addr, out_addr;
    logic [1:0]  lane_mask;

    logic        start1, issue_ready1, res_valid1;
    logic [7:0]  cfg_k_tiles1, cfg_row_tiles1, cfg_col_tiles1;
    logic        ready1, done1, err1, issue_valid1, first_k1, last_k1, out_we1;
    logic [13:0] in_addr1, wb_addr1, out_addr1;
    logic [1:0]  lane_mask1;

    int n_tests = 0;
    int n_fail  = 0;

    matmul_tile_sequencer #(.NUM_CORES(2), .DIM_W(8), .ADDR_W(14), .MAX_OUTSTANDING(4)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_k_tiles(cfg_k_tiles), .cfg_row_tiles(cfg_row_tiles), .cfg_col_tiles(cfg_col_tiles),
        .ready(ready), .done(done), .err(err),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in_addr(in_addr), .wb_addr(wb_addr), .first_k(first_k), .last_k(last_k),
        .lane_mask(lane_mask), .res_valid(res_valid), .out_we(out_we), .out_addr(out_addr)
    );

    matmul_tile_sequencer #(.NUM_CORES(2), .DIM_W(8), .ADDR_W(14), .MAX_OUTSTANDING(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .cfg_k_tiles(cfg_k_tiles1), .cfg_row_tiles(cfg_row_tiles1), .cfg_col_tiles(cfg_col_tiles1),
        .ready(ready1), .done(done1), .err(err1),
        .issue_valid(issue_valid1), .issue_ready(issue_ready1),
        .in_addr(in_addr1), .wb_addr(wb_addr1), .first_k(first_k1), .last_k(last_k1),
        .lane_mask(lane_mask1), .res_valid(res_valid1), .out_we(out_we1), .out_addr(out_addr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Runs one full job on u_dut with cores answering 3 cycles after each group's last beat.
    task automatic run_job(input bit toggle, input int kt, input int rt, input int ct, input int gt);
        logic        res_at [0:255];
        int          beat, ret, done_at, cyc, k, g, r, total;
        bit          fin;
        logic [31:0] obs, exp_v;
        logic [13:0] ein, ewb;
        logic [1:0]  em;
        for (int i = 0; i < 256; i++) res_at[i] = 1'b0;
        beat = 0; ret = 0; done_at = -1; fin = 1'b0; total = kt * rt * gt;
        @(negedge clk);
        cfg_k_tiles = 8'(kt); cfg_row_tiles = 8'(rt); cfg_col_tiles = 8'(ct);
        start = 1'b1; issue_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("ready_busy", 32'(ready), 32'd0);
        chk("err_clear", 32'(err), 32'd0);
        cyc = 0;
        while (cyc < 200 && !fin) begin
            issue_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            res_valid   = res_at[cyc];
            #1;
            if (res_valid) begin
                chk("out_we", 32'(out_we), 32'd1);
                chk("out_addr", 32'(out_addr), 32'(ret));
                ret++;
            end
            if (issue_valid) begin
                k = beat % kt;
                g = (beat / kt) % gt;
                r = beat / (kt * gt);
                ein = 14'(r * kt + k);
                ewb = 14'(g * kt + k);
                for (int i = 0; i < 2; i++) em[i] = ((g * 2 + i) < ct);
                obs   = {in_addr, wb_addr, first_k, last_k, lane_mask};
                exp_v = {ein, ewb, (k == 0), (k == kt - 1), em};
                chk("beat_in_range", 32'(beat < total), 32'd1);
                chk("beat_fields", obs, exp_v);
                if (issue_ready) begin
                    if (k == kt - 1) res_at[cyc + 3] = 1'b1;
                    beat++;
                end
            end
            if (done_at >= 0) begin
                chk("ready_after_done", 32'(ready), 32'd1);
                chk("done_single", 32'(done), 32'd0);
                fin = 1'b1;
            end else if (done) begin
                done_at = cyc;
                chk("beats_at_done", 32'(beat), 32'(total));
                chk("retires_at_done", 32'(ret), 32'(rt * gt));
            end
            cyc++;
            if (!fin) @(negedge clk);
        end
        issue_ready = 1'b0;
        res_valid   = 1'b0;
        chk("job_finished", 32'(fin), 32'd1);
    endtask

    initial begin
        bit held, seen;
        rst = 1'b1;
        start = 1'b0; issue_ready = 1'b0; res_valid = 1'b0;
        cfg_k_tiles = 8'd0; cfg_row_tiles = 8'd0; cfg_col_tiles = 8'd0;
        start1 = 1'b0; issue_ready1 = 1'b0; res_valid1 = 1'b0;
        cfg_k_tiles1 = 8'd0; cfg_row_tiles1 = 8'd0; cfg_col_tiles1 = 8'd0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_flags", 32'({done, err, issue_valid, first_k, last_k, out_we}), 32'd0);
        chk("rst_addrs", 32'({in_addr, wb_addr}), 32'd0);
        chk("rst_mask_oaddr", 32'({lane_mask, out_addr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_no_issue", 32'(issue_valid), 32'd0);

        // Scenario 1: free-flowing issue, K=2 R=4 C=3 -> 16 beats, 8 retires
        run_job(1'b0, 2, 4, 3, 2);

        // Scenario 2: same job, issue_ready toggling
        run_job(1'b1, 2, 4, 3, 2);

        // Scenario 4: zero row tiles -> error and immediate done
        @(negedge clk);
        cfg_k_tiles = 8'd2; cfg_row_tiles = 8'd0; cfg_col_tiles = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zcfg_err", 32'(err), 32'd1);
        chk("zcfg_done", 32'(done), 32'd1);
        chk("zcfg_no_issue", 32'(issue_valid), 32'd0);
        chk("zcfg_busy", 32'(ready), 32'd0);
        @(negedge clk);
        chk("zcfg_ready_next", 32'(ready), 32'd1);
        chk("zcfg_done_once", 32'(done), 32'd0);
        chk("zcfg_err_sticky", 32'(err), 32'd1);
        chk("zcfg_no_issue2", 32'(issue_valid), 32'd0);
        run_job(1'b0, 2, 4, 3, 2);

        // Scenario 5: stray result while idle
        @(negedge clk);
        res_valid = 1'b1;
        #1;
        chk("stray_no_we", 32'(out_we), 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        chk("stray_err", 32'(err), 32'd1);

        // Scenario 6: reset after five beats aborts the job
        @(negedge clk);
        cfg_k_tiles = 8'd2; cfg_row_tiles = 8'd4; cfg_col_tiles = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; issue_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_beat6", {in_addr, wb_addr, first_k, last_k, lane_mask},
            {14'd3, 14'd1, 1'b0, 1'b1, 2'b11});
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_no_issue", 32'(issue_valid), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        issue_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_done", 32'(done), 32'd0);
        run_job(1'b0, 2, 4, 3, 2);

        // Scenario 3: MAX_OUTSTANDING=1 instance, K=2 R=1 C=4 -> 2 groups of 2 beats
        @(negedge clk);
        cfg_k_tiles1 = 8'd2; cfg_row_tiles1 = 8'd1; cfg_col_tiles1 = 8'd4;
        start1 = 1'b1; issue_ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("mo_beat0", {issue_valid1, first_k1, wb_addr1}, {1'b1, 1'b1, 14'd0});
        @(negedge clk);
        chk("mo_beat1_last", 32'(last_k1), 32'd1);
        @(negedge clk);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (issue_valid1 !== 1'b0) held = 1'b0;
            @(negedge clk);
        end
        chk("mo_blocked", 32'(held), 32'd1);
        chk("mo_next_presented", {first_k1, wb_addr1}, {1'b1, 14'd2});
        res_valid1 = 1'b1;
        #1;
        chk("mo_ret0", {out_we1, out_addr1}, {1'b1, 14'd0});
        @(negedge clk);
        res_valid1 = 1'b0;
        chk("mo_resume", {issue_valid1, lane_mask1}, {1'b1, 2'b11});
        @(negedge clk);
        @(negedge clk);
        chk("mo_drain", 32'(issue_valid1), 32'd0);
        res_valid1 = 1'b1;
        #1;
        chk("mo_ret1", {out_we1, out_addr1}, {1'b1, 14'd1});
        @(negedge clk);
        res_valid1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("mo_done", 32'(seen), 32'd1);
        chk("mo_err", 32'(err1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
- Control and address engine for the multi-core matrix-multiply datapath: C = I x W, computed tile by tile.
- After a start handshake, walks the output tile space (row tile r, column group g, inner step k). For each beat it issues BRAM read addresses to the input and weight buffers.
- NUM_CORES cores consume one column group in parallel. A lane mask covers a partial last group.
- Counts retired results, bounds in-flight groups, generates output-BRAM write addresses and signals done.
- Generalises the fixed-dimension top: dimensions are runtime, core count is parametrised, and it adds backpressure and an outstanding-group limit.

Parameters:
- NUM_CORES, 2, cores per column group (1..32)
- DIM_W, 8, width of runtime tile-count config fields
- ADDR_W, 14, width of all BRAM address outputs
- MAX_OUTSTANDING, 4, max groups issued but not retired (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin job; accepted only when ready=1
- cfg_k_tiles  in  DIM_W  inner tiles (INNER_DIMENSION/BLOCK_SIZE)
- cfg_row_tiles  in  DIM_W  output row tiles (I_OUTER/BLOCK_SIZE)
- cfg_col_tiles  in  DIM_W  output col tiles (W_OUTER/BLOCK_SIZE)
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse when the job completes
- err  out  1  sticky error; cleared on the next accepted start
- issue_valid  out  1  beat address/flags valid
- issue_ready  in  1  cores accept beat
- in_addr  out  ADDR_W  input BRAM word = r*K + k
- wb_addr  out  ADDR_W  weight BRAM word = g*K + k
- first_k  out  1  k==0 (cores clear accumulators)
- last_k  out  1  k==K-1 (cores finalise tile)
- lane_mask  out  NUM_CORES  bit i = (g*NUM_CORES+i < cfg_col_tiles)
- res_valid  in  1  cores present one finished group
- out_we  out  1  output BRAM write strobe (combinational = res_valid && outstanding>0)
- out_addr  out  ADDR_W  output BRAM word, sequential retire index

Behaviour:
- Reset values: ready=1, done=0, err=0, issue_valid=0, all addresses 0, first_k=0, last_k=0, lane_mask=0. FSM in IDLE, all counters 0. Reset mid-job aborts immediately with no done.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start, latch cfg and clear err.
  - If any cfg field is 0, set err=1 and go to DONE.
  - Otherwise go to ISSUE with r=g=k=0 and c0=0.
  - start while not in IDLE is ignored.
- ISSUE:
  - issue_valid=1 except at a group boundary (k==0) while outstanding==MAX_OUTSTANDING; there it is held 0.
  - Outputs stay stable while issue_valid && !issue_ready.
  - On a beat (issue_valid && issue_ready), k increments. At k==K-1: k=0, g+1, c0+=NUM_CORES, outstanding+1.
  - When c0+NUM_CORES >= col_tiles at group end: g=0, c0=0, r+1.
  - After the final beat (r==R-1, last group, k==K-1), go to DRAIN with issue_valid=0 next cycle.
- Address/flag outputs are registered and derived from the current counters. Address arithmetic wraps modulo 2^ADDR_W; no overflow detection.
- Retire:
  - res_valid with outstanding>0 asserts out_we and out_addr=retire count, then retire+1 and outstanding-1.
  - res_valid with outstanding==0 sets err=1 and is ignored.
  - Group completion and retire in the same cycle leave outstanding unchanged.
- DRAIN: wait for outstanding==0, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE (ready=1 the following cycle).
- Totals: beats = R*G*K; retires = R*G, where G = ceil(col_tiles/NUM_CORES), computed by the c0 stepping, not by division.

Decomposition:
- Shared package matmul_pkg: FSM state enum, helper constant for clog2(MAX_OUTSTANDING+1) counter width, lane-mask width alias.
- One natural sub-module: tile_index_counter, the nested r/g/k counter with advance enable and wrap/last flags. It is reused later by the output readback path.

Test Plan:
1. NUM_CORES=2, K=2, R=4, C=3, issue_ready=1, res_valid 3 cycles after each last_k → 16 beats. Beat 1 in_addr=0, wb_addr=0, first_k=1. Beats in order: in_addr 0,1,0,1,2,3…; wb_addr 0,1,2,3,0,1…. lane_mask alternates 11,01. out_addr 0..7. done pulses once, ready=1 next cycle.
2. Same config with issue_ready toggling 1/0 each cycle → identical address sequence. Outputs held stable through every stall.
3. MAX_OUTSTANDING=1, res_valid withheld 20 cycles after the first group → issue_valid stays 0 at k=0 of group 2 until the retire, then resumes.
4. cfg_row_tiles=0, start → err=1 and done one cycle after start, no issue beats. Next valid start clears err.
5. res_valid while idle → err=1, out_we=0.
6. rst asserted mid-ISSUE after beat 5 → next cycle ready=1, issue_valid=0. A fresh start reproduces scenario 1 from beat 1.
